// File: rtl/cabac_bin_sched4_pkg.sv
// cabac_sched_pkg: shared limits, group-record field widths and FSM encodings
// for the CABAC bin-group scheduler.
package cabac_sched_pkg;
    localparam int CTX_W_DEF = 6;
    localparam int MAX_REG   = 4;
    localparam int MAX_ALL   = 8;
    localparam int NR_W      = 3;
    localparam int NA_W      = 4;
    localparam int MASK_W    = 8;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;
endpackage

// File: rtl/cabac_bin_sched4_if.sv
// cabac_bin_if / cabac_grp_if: binarizer-to-scheduler bin handshake and
// scheduler-to-range-stage group handshake.
interface cabac_bin_if
    import cabac_sched_pkg::*;
#(
    parameter int CTX_W = CTX_W_DEF
);
    logic             valid;
    logic             ready;
    logic             bypass;
    logic             val;
    logic [CTX_W-1:0] ctx;

    modport master (output valid, bypass, val, ctx, input ready);
    modport slave  (input valid, bypass, val, ctx, output ready);
endinterface

interface cabac_grp_if
    import cabac_sched_pkg::*;
#(
    parameter int CTX_W = CTX_W_DEF
);
    logic                          valid;
    logic                          ready;
    logic [NR_W-1:0]               number_range;
    logic [NA_W-1:0]               number_all;
    logic [MASK_W-1:0]             index_bypass;
    logic [MASK_W-1:0]             symbol_bypass;
    logic [MAX_REG-1:0]            reg_val;
    logic [MAX_REG-1:0][CTX_W-1:0] reg_ctx;

    modport master (output valid, number_range, number_all, index_bypass, symbol_bypass,
                    reg_val, reg_ctx, input ready);
    modport slave  (input valid, number_range, number_all, index_bypass, symbol_bypass,
                    reg_val, reg_ctx, output ready);
endinterface

// File: rtl/cabac_bin_sched4_conflict.sv
// cabac_ctx_conflict4: flags an incoming context that matches any occupied
// regular slot of the accumulator.
module cabac_ctx_conflict4
    import cabac_sched_pkg::*;
#(
    parameter int CTX_W = CTX_W_DEF
) (
    input  logic [CTX_W-1:0]              ctx_i,
    input  logic [MAX_REG-1:0][CTX_W-1:0] slot_ctx_i,
    input  logic [MAX_REG-1:0]            slot_vld_i,
    output logic                          hit_o
);
    always_comb begin
        hit_o = 1'b0;
        for (int k = 0; k < MAX_REG; k++)
            hit_o = hit_o | (slot_vld_i[k] & (slot_ctx_i[k] == ctx_i));
    end
endmodule

// File: rtl/cabac_bin_sched4.sv
// cabac_bin_sched4: packs binarized bins into groups of <=4 regular / <=8 total
// bins with unique contexts, and sequences end-of-slice drain.
module cabac_bin_sched4
    import cabac_sched_pkg::*;
#(
    parameter int CTX_W = CTX_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        flush_req_i,
    output logic        flush_done_o,
    cabac_bin_if.slave  bin_io,
    cabac_grp_if.master grp_io
);
    typedef struct packed {
        logic [NA_W-1:0]               cnt;
        logic [NR_W-1:0]               rcnt;
        logic [MASK_W-1:0]             mask;
        logic [MASK_W-1:0]             sym;
        logic [MAX_REG-1:0]            rval;
        logic [MAX_REG-1:0][CTX_W-1:0] rctx;
    } grp_t;

    grp_t               a_q, a_d, g_q, g_d, base, app;
    logic               g_vld_q, g_vld_d, hold_q, hold_d;
    state_e             state_q, state_d;
    logic [MAX_REG-1:0] slot_vld;
    logic               hit, conflict, post_close, close_needed, g_free, draining;
    logic               accept, drain_xfer, ld_a, ld_app, consumed;

    always_comb
        for (int k = 0; k < MAX_REG; k++)
            slot_vld[k] = a_q.rcnt > NR_W'(k);

    cabac_ctx_conflict4 #(.CTX_W(CTX_W)) u_conflict (
        .ctx_i      (bin_io.ctx),
        .slot_ctx_i (a_q.rctx),
        .slot_vld_i (slot_vld),
        .hit_o      (hit)
    );

    // A conflicting regular bin is appended to an empty accumulator, since the
    // old contents leave for the group register on the same edge.
    always_comb begin
        conflict = !bin_io.bypass & hit;
        base = conflict ? '0 : a_q;
        app = base;
        app.mask[base.cnt[2:0]] = bin_io.bypass;
        app.sym[base.cnt[2:0]] = bin_io.bypass & bin_io.val;
        if (!bin_io.bypass) begin
            app.rval[base.rcnt[1:0]] = bin_io.val;
            app.rctx[base.rcnt[1:0]] = bin_io.ctx;
        end
        app.cnt = base.cnt + NA_W'(1);
        app.rcnt = base.rcnt + NR_W'(!bin_io.bypass);
        post_close = (app.rcnt == NR_W'(MAX_REG)) || (app.cnt == NA_W'(MAX_ALL));
    end

    assign close_needed = conflict | post_close;
    assign g_free       = !g_vld_q | grp_io.ready;
    assign draining     = state_q == S_DRAIN;
    assign bin_io.ready = en_i & !draining & !(close_needed & !g_free);
    assign accept       = bin_io.valid & bin_io.ready;
    assign drain_xfer   = draining & (a_q.cnt != '0) & g_free;
    assign ld_a         = (accept & conflict) | drain_xfer;
    assign ld_app       = accept & post_close;
    assign consumed     = g_vld_q & grp_io.ready;
    assign flush_done_o = en_i & draining & (a_q.cnt == '0) & !g_vld_q;

    always_comb begin
        a_d = (!en_i || ld_app || drain_xfer) ? '0 : accept ? app : a_q;
        g_d = !en_i ? '0 : ld_a ? a_q : ld_app ? app : consumed ? '0 : g_q;
        g_vld_d = en_i & (ld_a | ld_app | (g_vld_q & !grp_io.ready));
    end

    // A completed flush is held off until flush_req drops, so one request
    // produces exactly one flush_done pulse.
    always_comb begin
        state_d = state_q;
        hold_d = en_i & flush_req_i & (hold_q | flush_done_o);
        if (draining) begin
            state_d = flush_done_o ? S_EMPTY : S_DRAIN;
        end else begin
            if (accept) state_d = post_close ? S_EMPTY : S_FILL;
            if (flush_req_i && !hold_q) state_d = S_DRAIN;
        end
        if (!en_i) state_d = S_EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            g_q     <= '0;
            g_vld_q <= 1'b0;
            hold_q  <= 1'b0;
            state_q <= S_EMPTY;
        end else begin
            a_q     <= a_d;
            g_q     <= g_d;
            g_vld_q <= g_vld_d;
            hold_q  <= hold_d;
            state_q <= state_d;
        end
    end

    assign grp_io.valid         = g_vld_q;
    assign grp_io.number_range  = g_q.rcnt;
    assign grp_io.number_all    = g_q.cnt;
    assign grp_io.index_bypass  = g_q.mask;
    assign grp_io.symbol_bypass = g_q.sym;
    assign grp_io.reg_val       = g_q.rval;
    assign grp_io.reg_ctx       = g_q.rctx;
endmodule
